ps2_keyboard: RTL

PS/2 keyboard receiver that produces the Hack memory-mapped keyboard word. It sits upstream of the data memory and feeds the read-only KBD register at address 0x6000 (24576), which the CPU samples through inM. It decodes a scan-code set-2 byte stream into the Hack character code of the key currently held, and reports 0 when no mapped key is held.

---
 rtl/ps2_keyboard.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard.sv
// ps2_keyboard
// PS/2 keyboard receiver producing the Hack KBD word. Decodes a scan-code
// set-2 byte stream into the Hack character code of the key currently held,
// or 0 when no mapped key is held.
//
// Parameters:
//   FILTER_LEN      consecutive equal ps2_clk samples needed to accept a level change
//   TIMEOUT_CYCLES  clk cycles without a ps2_clk falling edge before a partial frame is dropped
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   kbd_out    Hack key code of the held key, or 0
//   frame_err  one-cycle pulse on bad start/parity/stop bit or timeout
module ps2_keyboard #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbd_out,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizers and ps2_clk glitch filter
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic          filt_clk_reg;
    logic [FW-1:0] filt_cnt_reg;

    logic clk_s;
    logic data_s;
    logic filt_flip;
    logic fall_edge;

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];

    // The filtered level flips on the FILTER_LEN-th consecutive sample that
    // disagrees with it; any agreeing sample restarts the run.
    assign filt_flip = (clk_s != filt_clk_reg) && (filt_cnt_reg == FW'(FILTER_LEN - 1));
    assign fall_edge = filt_flip && filt_clk_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            filt_clk_reg  <= 1'b1;
            filt_cnt_reg  <= '0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            if (clk_s == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_flip) begin
                filt_clk_reg <= clk_s;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [7:0]    sr_reg, sr_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic          par_reg, par_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          byte_valid_reg, byte_valid_next;
    logic          frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            sr_reg         <= '0;
            bit_cnt_reg    <= '0;
            par_reg        <= 1'b0;
            to_cnt_reg     <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            bit_cnt_reg    <= bit_cnt_next;
            par_reg        <= par_next;
            to_cnt_reg     <= to_cnt_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sr_next         = sr_reg;
        bit_cnt_next    = bit_cnt_reg;
        par_next        = par_reg;
        to_cnt_next     = to_cnt_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        if (fall_edge) begin
            // An edge always wins over a simultaneous timeout.
            to_cnt_next = '0;
            case (state_reg)
                S_IDLE: begin
                    if (!data_s) begin
                        state_next   = S_DATA;
                        bit_cnt_next = '0;
                        sr_next      = '0;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
                S_DATA: begin
                    sr_next      = {data_s, sr_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_next   = data_s;
                    state_next = S_STOP;
                end
                S_STOP: begin
                    // Odd parity: data bits plus parity bit hold an odd count of ones.
                    if (data_s && (^{sr_reg, par_reg})) begin
                        byte_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end else if (state_reg != S_IDLE) begin
            if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err_next = 1'b1;
                state_next     = S_IDLE;
                sr_next        = '0;
                bit_cnt_next   = '0;
                to_cnt_next    = '0;
            end else begin
                to_cnt_next = to_cnt_reg + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequence decoder and scan-code map. sr_reg still holds the received
    // byte while byte_valid_reg is high: it is only rewritten by a new start bit.
    // ------------------------------------------------------------------
    logic        ext_reg, ext_next;
    logic        brk_reg, brk_next;
    logic [15:0] kbd_out_reg, kbd_out_next;
    logic [15:0] code;

    always_comb begin
        code = 16'd0;
        if (ext_reg) begin
            case (sr_reg)
                8'h6B:   code = 16'd130;
                8'h75:   code = 16'd131;
                8'h74:   code = 16'd132;
                8'h72:   code = 16'd133;
                default: code = 16'd0;
            endcase
        end else begin
            case (sr_reg)
                8'h1C: code = 16'd65;  8'h32: code = 16'd66;  8'h21: code = 16'd67;
                8'h23: code = 16'd68;  8'h24: code = 16'd69;  8'h2B: code = 16'd70;
                8'h34: code = 16'd71;  8'h33: code = 16'd72;  8'h43: code = 16'd73;
                8'h3B: code = 16'd74;  8'h42: code = 16'd75;  8'h4B: code = 16'd76;
                8'h3A: code = 16'd77;  8'h31: code = 16'd78;  8'h44: code = 16'd79;
                8'h4D: code = 16'd80;  8'h15: code = 16'd81;  8'h2D: code = 16'd82;
                8'h1B: code = 16'd83;  8'h2C: code = 16'd84;  8'h3C: code = 16'd85;
                8'h2A: code = 16'd86;  8'h1D: code = 16'd87;  8'h22: code = 16'd88;
                8'h35: code = 16'd89;  8'h1A: code = 16'd90;
                8'h45: code = 16'd48;  8'h16: code = 16'd49;  8'h1E: code = 16'd50;
                8'h26: code = 16'd51;  8'h25: code = 16'd52;  8'h2E: code = 16'd53;
                8'h36: code = 16'd54;  8'h3D: code = 16'd55;  8'h3E: code = 16'd56;
                8'h46: code = 16'd57;
                8'h29: code = 16'd32;  8'h5A: code = 16'd128;
                8'h66: code = 16'd129; 8'h76: code = 16'd140;
                default: code = 16'd0;
            endcase
        end
    end

    always_comb begin
        ext_next     = ext_reg;
        brk_next     = brk_reg;
        kbd_out_next = kbd_out_reg;
        if (frame_err_reg) begin
            ext_next = 1'b0;
            brk_next = 1'b0;
        end else if (byte_valid_reg) begin
            if (sr_reg == 8'hE0) begin
                ext_next = 1'b1;
            end else if (sr_reg == 8'hF0) begin
                brk_next = 1'b1;
            end else begin
                ext_next = 1'b0;
                brk_next = 1'b0;
                if (!brk_reg) begin
                    if (code != 16'd0) begin
                        kbd_out_next = code;
                    end
                end else if (code == kbd_out_reg) begin
                    kbd_out_next = 16'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
            kbd_out_reg <= 16'd0;
        end else begin
            ext_reg     <= ext_next;
            brk_reg     <= brk_next;
            kbd_out_reg <= kbd_out_next;
        end
    end

    assign kbd_out   = kbd_out_reg;
    assign frame_err = frame_err_reg;

endmodule
